// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with registered read data.
// Arbitration is round-robin, and a port can hold a bounded lock on the RAM.
module mem_arbiter #(
    parameter int data_width = 32,
    parameter int addr_width = 4,
    parameter int max_lock   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [data_width-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [data_width-1:0] b_rdata,
    output logic [addr_width-1:0] ram_read_address,
    output logic [addr_width-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCK_A = 2'd1;
    localparam logic [1:0] LOCK_B = 2'd2;
    localparam logic       LG_A   = 1'b0;
    localparam logic       LG_B   = 1'b1;
    localparam logic [3:0] MAX_LOCK = 4'(max_lock);

    logic [1:0] state_q, state_d;
    logic       lg_q, lg_d;
    logic [3:0] lcnt_q, lcnt_d;
    logic       a_rvalid_q, a_rvalid_d;
    logic       b_rvalid_q, b_rvalid_d;
    logic       hold_a, hold_b;

    // A lock only wins unconditionally while its owner keeps asking and
    // has not used up its run; otherwise fall back to round-robin.
    always_comb begin
        hold_a = (state_q == LOCK_A) && a_req && a_lock && (lcnt_q < MAX_LOCK);
        hold_b = (state_q == LOCK_B) && b_req && b_lock && (lcnt_q < MAX_LOCK);
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        if (reset) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end else if (hold_a) begin
            a_gnt = 1'b1;
        end else if (hold_b) begin
            b_gnt = 1'b1;
        end else if (a_req && b_req) begin
            if (lg_q == LG_B) a_gnt = 1'b1;
            else              b_gnt = 1'b1;
        end else if (a_req) begin
            a_gnt = 1'b1;
        end else if (b_req) begin
            b_gnt = 1'b1;
        end
    end

    always_comb begin
        state_d    = IDLE;
        lcnt_d     = 4'd0;
        lg_d       = lg_q;
        a_rvalid_d = a_gnt && !a_we;
        b_rvalid_d = b_gnt && !b_we;
        if (a_gnt) begin
            lg_d = LG_A;
            if (a_lock) begin
                state_d = LOCK_A;
                if (state_q == LOCK_A) lcnt_d = (lcnt_q == 4'hf) ? lcnt_q : lcnt_q + 4'd1;
                else                   lcnt_d = 4'd1;
            end
        end else if (b_gnt) begin
            lg_d = LG_B;
            if (b_lock) begin
                state_d = LOCK_B;
                if (state_q == LOCK_B) lcnt_d = (lcnt_q == 4'hf) ? lcnt_q : lcnt_q + 4'd1;
                else                   lcnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lg_q       <= LG_B;
            lcnt_q     <= 4'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lg_q       <= lg_d;
            lcnt_q     <= lcnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Port A drives the RAM address/data whenever B is not granted.
    assign ram_read_address  = b_gnt ? b_addr : a_addr;
    assign ram_write_address = b_gnt ? b_addr : a_addr;
    assign ram_din           = b_gnt ? b_wdata : a_wdata;
    assign ram_write         = (a_gnt && a_we) || (b_gnt && b_we);

    // Reset masks a read still in flight from the cycle before it.
    assign a_rvalid = a_rvalid_q && !reset;
    assign b_rvalid = b_rvalid_q && !reset;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and an rvalid/rdata
// scoreboard fed from the expected grant of every driven cycle.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_read_address, ram_write_address;
    logic          ram_write;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ref_mem [16];
    logic [DW+1:0] exp_q [$];
    int            checks;
    int            errors;

    mem_arbiter #(.data_width(DW), .addr_width(AW), .max_lock(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_write_address] <= ram_din;
        ram_dout <= ram_mem[ram_read_address];
    end

    // One cycle: drive inputs at negedge, score last cycle's read, queue this one.
    task automatic drive(input logic rst_v,
                         input logic ar, input logic awe, input logic alk,
                         input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                         input logic br, input logic bwe, input logic blk,
                         input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
                         input logic eg_a, input logic eg_b);
        logic [DW+1:0] e;
        @(negedge clk);
        reset = rst_v;
        a_req = ar; a_we = awe; a_lock = alk; a_addr = aad; a_wdata = awd;
        b_req = br; b_we = bwe; b_lock = blk; b_addr = bad; b_wdata = bwd;
        if (rst_v && exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a_rvalid !== e[DW+1] || b_rvalid !== e[DW]) begin
                errors++;
                $display("FAIL rvalid t=%0t: got a=%b b=%b, expected a=%b b=%b",
                         $time, a_rvalid, b_rvalid, e[DW+1], e[DW]);
            end
            if (e[DW+1]) begin
                checks++;
                if (a_rdata !== e[DW-1:0]) begin
                    errors++;
                    $display("FAIL a_rdata t=%0t: got %h, expected %h", $time, a_rdata, e[DW-1:0]);
                end
            end
            if (e[DW]) begin
                checks++;
                if (b_rdata !== e[DW-1:0]) begin
                    errors++;
                    $display("FAIL b_rdata t=%0t: got %h, expected %h", $time, b_rdata, e[DW-1:0]);
                end
            end
        end
        e = '0;
        if (eg_a && !awe)      e = {2'b10, ref_mem[aad]};
        else if (eg_b && !bwe) e = {2'b01, ref_mem[bad]};
        exp_q.push_back(e);
        if (eg_a && awe) ref_mem[aad] = awd;
        if (eg_b && bwe) ref_mem[bad] = bwd;
    endtask

    task automatic idle_cycle(input logic rst_v);
        drive(rst_v, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 0, 4'd1, 32'h1111_0000, 1, 0, 0, 4'd2, '0, 0, 0);
            checks++;
            if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || ram_write !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: gnt a=%b b=%b ram_write=%b, expected 0 0 0",
                         a_gnt, b_gnt, ram_write);
            end
        end
        idle_cycle(0);
        checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: a=%b b=%b, expected 0 0", a_rvalid, b_rvalid);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            drive(0, 1, 1, 0, 4'(i), d, 0, 0, 0, '0, '0, 1, 0);
            checks++;
            if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_write !== 1'b1 ||
                ram_write_address !== 4'(i) || ram_din !== d) begin
                errors++;
                $display("FAIL fill_write[%0d]: gnt a=%b b=%b we=%b wa=%h din=%h, expected 1 0 1 %h %h",
                         i, a_gnt, b_gnt, ram_write, ram_write_address, ram_din, 4'(i), d);
            end
        end
    endtask

    task automatic test_round_robin();
        logic ea;
        idle_cycle(1);
        for (int i = 0; i < 4; i++) begin
            ea = (i % 2 == 0);
            drive(0, 1, 0, 0, 4'd1, '0, 1, 0, 0, 4'd2, '0, ea, !ea);
            checks++;
            if (a_gnt !== ea || b_gnt !== !ea || ram_write !== 1'b0 ||
                ram_read_address !== (ea ? 4'd1 : 4'd2)) begin
                errors++;
                $display("FAIL round_robin[%0d]: gnt a=%b b=%b we=%b ra=%h, expected %b %b 0 %h",
                         i, a_gnt, b_gnt, ram_write, ram_read_address, ea, !ea, ea ? 4'd1 : 4'd2);
            end
        end
    endtask

    task automatic test_write_then_read();
        drive(0, 1, 1, 0, 4'd3, 32'hDEAD_BEEF, 0, 0, 0, 4'd9, '0, 1, 0);
        checks++;
        if (a_gnt !== 1'b1 || ram_write !== 1'b1 || ram_din !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_cycle: gnt=%b we=%b din=%h, expected 1 1 deadbeef", a_gnt, ram_write, ram_din);
        end
        drive(0, 0, 0, 0, 4'd0, '0, 1, 0, 0, 4'd3, '0, 0, 1);
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || ram_write !== 1'b0 || ram_read_address !== 4'd3) begin
            errors++;
            $display("FAIL rd_cycle: gnt a=%b b=%b we=%b ra=%h, expected 0 1 0 3",
                     a_gnt, b_gnt, ram_write, ram_read_address);
        end
        idle_cycle(0);
        checks++;
        if (ram_write !== 1'b0) begin
            errors++;
            $display("FAIL wr_after: ram_write=%b, expected 0", ram_write);
        end
    endtask

    task automatic test_lock();
        logic [5:0] pat;
        pat = 6'b101111;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 1, 4'd5, '0, 1, 0, 0, 4'd6, '0, pat[i], !pat[i]);
            checks++;
            if (a_gnt !== pat[i] || b_gnt !== !pat[i]) begin
                errors++;
                $display("FAIL lock_seq[%0d]: gnt a=%b b=%b, expected %b %b",
                         i, a_gnt, b_gnt, pat[i], !pat[i]);
            end
        end
    endtask

    task automatic test_lock_drop();
        drive(0, 0, 0, 1, 4'd5, '0, 1, 0, 0, 4'd7, '0, 0, 1);
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lock_drop: gnt a=%b b=%b, expected 0 1", a_gnt, b_gnt);
        end
        drive(0, 1, 0, 0, 4'd8, '0, 1, 0, 0, 4'd9, '0, 1, 0);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL lock_drop_after: gnt a=%b b=%b, expected 1 0", a_gnt, b_gnt);
        end
    endtask

    task automatic test_reset_rvalid();
        drive(0, 0, 0, 0, '0, '0, 1, 0, 0, 4'd7, '0, 0, 1);
        checks++;
        if (b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_grant: b_gnt=%b, expected 1", b_gnt);
        end
        idle_cycle(1);
        checks++;
        if (b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rvalid_mask: b_rvalid=%b, expected 0", b_rvalid);
        end
        idle_cycle(1);
        drive(0, 1, 0, 0, 4'd10, '0, 1, 0, 0, 4'd11, '0, 1, 0);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_grant: gnt a=%b b=%b, expected 1 0", a_gnt, b_gnt);
        end
        drive(0, 1, 0, 0, 4'd10, '0, 1, 0, 0, 4'd11, '0, 0, 1);
        checks++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_second_grant: gnt a=%b b=%b, expected 0 1", a_gnt, b_gnt);
        end
    endtask

    task automatic test_idle();
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        for (int i = 0; i < 10; i++) begin
            ad = 4'($urandom_range(0, 15));
            wd = $urandom;
            drive(0, 0, 1, 0, ad, wd, 0, 1, 0, ~ad, ~wd, 0, 0);
            checks++;
            if (ram_write !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0 ||
                ram_read_address !== ad || ram_write_address !== ad || ram_din !== wd) begin
                errors++;
                $display("FAIL idle[%0d]: we=%b gnt=%b%b ra=%h wa=%h din=%h, expected 0 00 %h %h %h",
                         i, ram_write, a_gnt, b_gnt, ram_read_address, ram_write_address, ram_din,
                         ad, ad, wd);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        test_reset();
        test_fill();
        test_round_robin();
        test_write_then_read();
        test_lock();
        test_lock_drop();
        test_reset_rvalid();
        test_idle();
        idle_cycle(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
